// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with registered read data; SYNC_FIFO_ERR_FLAGS_EN adds sticky overflow/underflow outputs
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16,
  parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [WIDTH-1:0]      wr_data,
  output logic                  full,
  input  logic                  rd_en,
  output logic [WIDTH-1:0]      rd_data,
  output logic                  empty,
  output logic [ADDR_WIDTH:0]   count
`ifdef SYNC_FIFO_ERR_FLAGS_EN
  ,
  output logic                  overflow,
  output logic                  underflow
`endif
);
  localparam logic [ADDR_WIDTH:0] full_cnt = DEPTH[ADDR_WIDTH:0];
  logic [WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH:0] wr_ptr, rd_ptr;
  logic wr_ok, rd_ok;
  // the extra pointer MSB lets the difference reach DEPTH without aliasing to zero
  assign count = wr_ptr - rd_ptr;
  assign full = count == full_cnt;
  assign empty = count == '0;
  assign wr_ok = wr_en & ~full;
  assign rd_ok = rd_en & ~empty;
  always_ff @(posedge clk)
    if (wr_ok) mem[wr_ptr[ADDR_WIDTH-1:0]] <= wr_data;
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      rd_data <= '0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
      if (rd_ok) begin
        rd_ptr <= rd_ptr + 1'b1;
        rd_data <= mem[rd_ptr[ADDR_WIDTH-1:0]];
      end
    end
  end
`ifdef SYNC_FIFO_ERR_FLAGS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_en && full) overflow <= 1'b1;
      if (rd_en && empty) underflow <= 1'b1;
    end
  end
`endif
endmodule

// File: tb/tb_sync_fifo.sv
// tb_sync_fifo: scoreboard-based self-checking bench for sync_fifo
module tb_sync_fifo;
  logic clk = 0;
  logic rst = 1;
  logic wr_en = 0;
  logic rd_en = 0;
  logic [31:0] wr_data = '0;
  logic [31:0] rd_data;
  logic full, empty;
  logic [4:0] count;
`ifdef SYNC_FIFO_ERR_FLAGS_EN
  logic overflow, underflow;
`endif
  int total = 0;
  int bad = 0;
  logic [31:0] q [$];
  logic [31:0] rd_exp = '0;

  sync_fifo #(.WIDTH(32), .DEPTH(16)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .full(full),
    .rd_en(rd_en), .rd_data(rd_data), .empty(empty), .count(count)
`ifdef SYNC_FIFO_ERR_FLAGS_EN
    , .overflow(overflow), .underflow(underflow)
`endif
  );

  always #5 clk = ~clk;

  // one clock of stimulus; the model decides acceptance from its own occupancy
  task automatic drive(input logic w, input logic [31:0] d, input logic r);
    bit wa, ra;
    wa = w && q.size() < 16;
    ra = r && q.size() > 0;
    wr_en = w;
    wr_data = d;
    rd_en = r;
    @(posedge clk);
    if (ra) rd_exp = q.pop_front();
    if (wa) q.push_back(d);
    #1;
    wr_en = 0;
    rd_en = 0;
  endtask

  task automatic test_reset();
    rst = 1;
    repeat (5) @(posedge clk);
    #1;
    rst = 0;
    q.delete();
    rd_exp = '0;
    total++; if (empty !== 1'b1) begin bad++; $display("FAIL reset_empty got=%b exp=1", empty); end
    total++; if (full !== 1'b0) begin bad++; $display("FAIL reset_full got=%b exp=0", full); end
    total++; if (count !== 5'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", count); end
    total++; if (rd_data !== 32'h0) begin bad++; $display("FAIL reset_rd_data got=%h exp=0", rd_data); end
  endtask

  task automatic test_basic_order();
    for (int i = 0; i < 8; i++) begin
      drive(1, 32'hDEADBEE0 + i, 0);
      total++; if (count !== 5'(q.size())) begin bad++; $display("FAIL basic_wr_count got=%0d exp=%0d", count, q.size()); end
    end
    for (int i = 0; i < 8; i++) begin
      drive(0, 0, 1);
      total++; if (rd_data !== 32'hDEADBEE0 + i) begin bad++; $display("FAIL basic_rd_data got=%h exp=%h", rd_data, 32'hDEADBEE0 + i); end
    end
    total++; if (empty !== 1'b1) begin bad++; $display("FAIL basic_empty got=%b exp=1", empty); end
  endtask

  task automatic test_fill_drain();
    for (int i = 0; i < 16; i++) drive(1, 32'hCAFE0000 + i, 0);
    total++; if (full !== 1'b1) begin bad++; $display("FAIL fill_full got=%b exp=1", full); end
    total++; if (count !== 5'd16) begin bad++; $display("FAIL fill_count got=%0d exp=16", count); end
    drive(1, 32'h12345678, 0);
    total++; if (count !== 5'd16) begin bad++; $display("FAIL overfill_count got=%0d exp=16", count); end
`ifdef SYNC_FIFO_ERR_FLAGS_EN
    total++; if (overflow !== 1'b1) begin bad++; $display("FAIL overflow_flag got=%b exp=1", overflow); end
`endif
    for (int i = 0; i < 16; i++) begin
      drive(0, 0, 1);
      total++; if (rd_data !== 32'hCAFE0000 + i) begin bad++; $display("FAIL drain_rd_data got=%h exp=%h", rd_data, 32'hCAFE0000 + i); end
    end
    total++; if (empty !== 1'b1) begin bad++; $display("FAIL drain_empty got=%b exp=1", empty); end
    total++; if (count !== 5'd0) begin bad++; $display("FAIL drain_count got=%0d exp=0", count); end
    drive(0, 0, 1);
    total++; if (rd_data !== 32'hCAFE000F) begin bad++; $display("FAIL underread_hold got=%h exp=cafe000f", rd_data); end
    total++; if (empty !== 1'b1 || full !== 1'b0) begin bad++; $display("FAIL underread_flags got=%b%b exp=10", empty, full); end
`ifdef SYNC_FIFO_ERR_FLAGS_EN
    total++; if (underflow !== 1'b1) begin bad++; $display("FAIL underflow_flag got=%b exp=1", underflow); end
`endif
  endtask

  task automatic test_simultaneous();
    for (int i = 0; i < 8; i++) drive(1, 32'hABCD0000 + i, 0);
    for (int i = 0; i < 5; i++) begin
      drive(1, 32'hEF000000 + i, 1);
      total++; if (count !== 5'd8) begin bad++; $display("FAIL simul_count got=%0d exp=8", count); end
      total++; if (rd_data !== 32'hABCD0000 + i) begin bad++; $display("FAIL simul_rd_data got=%h exp=%h", rd_data, 32'hABCD0000 + i); end
    end
    while (q.size() > 0) begin
      drive(0, 0, 1);
      total++; if (rd_data !== rd_exp) begin bad++; $display("FAIL simul_drain got=%h exp=%h", rd_data, rd_exp); end
    end
    // both requested on an empty FIFO: only the write lands
    drive(1, 32'h5A5A0001, 1);
    total++; if (count !== 5'd1 || rd_data !== rd_exp) begin bad++; $display("FAIL simul_empty got=%0d/%h exp=1/%h", count, rd_data, rd_exp); end
    drive(0, 0, 1);
    total++; if (rd_data !== 32'h5A5A0001) begin bad++; $display("FAIL simul_empty_rd got=%h exp=5a5a0001", rd_data); end
  endtask

  task automatic test_wrap();
    for (int p = 0; p < 3; p++) begin
      for (int i = 0; i < 16; i++) begin
        drive(1, 32'h77000000 + (p << 8) + i, 0);
        total++; if (count !== 5'(q.size()) || full !== (q.size() == 16) || empty !== 1'b0) begin
          bad++; $display("FAIL wrap_fill got=%0d/%b%b exp=%0d", count, full, empty, q.size()); end
      end
      // simultaneous on full: only the read lands
      drive(1, 32'hBAD0BAD0, 1);
      total++; if (count !== 5'd15 || rd_data !== rd_exp) begin bad++; $display("FAIL wrap_full_rw got=%0d/%h exp=15/%h", count, rd_data, rd_exp); end
      while (q.size() > 0) begin
        drive(0, 0, 1);
        total++; if (rd_data !== rd_exp || count !== 5'(q.size()) || empty !== (q.size() == 0) || full !== 1'b0) begin
          bad++; $display("FAIL wrap_drain got=%h/%0d exp=%h/%0d", rd_data, count, rd_exp, q.size()); end
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 100; i++) begin
      logic w, r;
      w = $urandom_range(0, 1) == 1 && q.size() < 16;
      r = $urandom_range(0, 1) == 1 && q.size() > 0;
      drive(w, $urandom, r);
      total++; if (rd_data !== rd_exp) begin bad++; $display("FAIL rand_rd_data got=%h exp=%h", rd_data, rd_exp); end
      total++; if (count !== 5'(q.size()) || count > 5'd16) begin bad++; $display("FAIL rand_count got=%0d exp=%0d", count, q.size()); end
      total++; if (empty !== (count == 0) || full !== (count == 16) || (full && empty)) begin
        bad++; $display("FAIL rand_flags got=%b%b exp=%b%b", full, empty, q.size() == 16, q.size() == 0); end
    end
  endtask

  task automatic test_mid_reset();
    for (int i = 0; i < 3; i++) drive(1, 32'h31000000 + i, 0);
    drive(0, 0, 1);
    rst = 1;
    wr_en = 1;
    rd_en = 1;
    @(posedge clk);
    #1;
    rst = 0;
    wr_en = 0;
    rd_en = 0;
    q.delete();
    rd_exp = '0;
    total++; if (count !== 5'd0 || empty !== 1'b1) begin bad++; $display("FAIL midrst_state got=%0d/%b exp=0/1", count, empty); end
    total++; if (rd_data !== 32'h0) begin bad++; $display("FAIL midrst_rd_data got=%h exp=0", rd_data); end
`ifdef SYNC_FIFO_ERR_FLAGS_EN
    total++; if (overflow !== 1'b0 || underflow !== 1'b0) begin bad++; $display("FAIL midrst_err got=%b%b exp=00", overflow, underflow); end
`endif
    drive(1, 32'h42424242, 0);
    drive(0, 0, 1);
    total++; if (rd_data !== 32'h42424242) begin bad++; $display("FAIL midrst_after got=%h exp=42424242", rd_data); end
  endtask

  initial begin
    test_reset();
    test_basic_order();
    test_fill_drain();
    test_simultaneous();
    test_wrap();
    test_random();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/sync_fifo.md
Name: sync_fifo

Overview:
Single-clock first-in/first-out buffer for WIDTH-bit words with DEPTH entries. It decouples a producer and a consumer running in the same clock domain. It exposes full/empty flags and an occupancy count. Read data is registered, with one-cycle latency.

Parameters:
WIDTH, 32, data word width in bits (>=1).
DEPTH, 16, number of entries; must be a power of two, >=2.
ADDR_WIDTH, $clog2(DEPTH), pointer index width; derived, do not override.

Ports:
clk  input  1  rising-edge clock for all logic
rst  input  1  synchronous reset, active-high
wr_en  input  1  write request
wr_data  input  WIDTH  data to write
full  output  1  FIFO holds DEPTH entries
rd_en  input  1  read request
rd_data  output  WIDTH  registered read data
empty  output  1  FIFO holds 0 entries
count  output  ADDR_WIDTH+1  current occupancy, 0..DEPTH

Behaviour:
- Clocking and reset: single clock (clk). Reset is synchronous and active-high (rst).
- Reset state (on a rising clk edge with rst=1):
  - read and write pointers = 0; count = 0; empty = 1; full = 0; rd_data = 0.
  - Storage array is not reset; its contents are don't-care.
  - Reset overrides any wr_en/rd_en in the same cycle.
  - Reset mid-operation discards all stored data.
- Write accept: wr_en=1 and full=0 at a rising edge.
  - mem[wr_ptr] <= wr_data; wr_ptr advances by 1.
- Write when full: ignored; no state change.
- Read accept: rd_en=1 and empty=0 at a rising edge.
  - rd_data <= mem[rd_ptr]; rd_ptr advances by 1.
  - Data is visible on rd_data after that same edge (1-cycle latency).
- Read when empty: ignored; rd_data holds its previous value.
- rd_data holds its last value whenever no read is accepted.
- Pointers: ADDR_WIDTH+1 bits each; the low ADDR_WIDTH bits index memory.
  - They wrap naturally modulo 2*DEPTH; the extra MSB disambiguates full from empty.
- count = wr_ptr - rd_ptr, modulo 2^(ADDR_WIDTH+1). It never exceeds DEPTH.
- Flags:
  - full = (count == DEPTH); empty = (count == 0).
  - Both are derived from the registered pointers, so they update the cycle after the accepting edge.
  - Invariants: empty == (count==0); full == (count==DEPTH); never both 1.
- Simultaneous wr_en and rd_en:
  - Each is qualified independently (write needs !full, read needs !empty).
  - Both accepted: count unchanged, both pointers advance, read returns the oldest entry.
  - Empty: only the write is accepted; count becomes 1.
  - Full: only the read is accepted; count becomes DEPTH-1.
- Ordering: strict FIFO order; no data loss or duplication across pointer wrap-around.

Optional Feature:
Macro SYNC_FIFO_ERR_FLAGS_EN.
- Defined: adds two output ports, overflow (1 bit) and underflow (1 bit), both sticky.
  - overflow sets when wr_en=1 while full=1.
  - underflow sets when rd_en=1 while empty=1.
  - Both clear only on rst.
- Not defined: the ports and their logic are absent. All other behaviour is identical.

Test Plan:
- Reset: hold rst=1 for 5 cycles, then release -> empty=1, full=0, count=0, rd_data=0.
- Basic order: write 0xDEADBEE0..0xDEADBEE7 as single-cycle pulses, then 8 single-cycle reads -> rd_data returns 0xDEADBEE0..0xDEADBEE7 in order, each visible the edge after its read.
- Fill/drain:
  - Write 16 words 0xCAFE0000+i -> full=1, count=16.
  - An extra write of 0x12345678 is ignored.
  - 16 reads return 0xCAFE0000..0xCAFE000F -> empty=1, count=0.
  - An extra read leaves rd_data=0xCAFE000F.
- Simultaneous: pre-fill 8 words 0xABCD0000+i, then 5 cycles with wr_en=rd_en=1 writing 0xEF000000+i -> count stays 8; reads return 0xABCD0000..0xABCD0004.
- Wrap-around: run 3 full fill/drain passes -> data order intact; count and flags correct throughout.
- Random: 100 random write/read ops, gated on !full/!empty, checked against a reference queue -> data always matches; count<=16; flag invariants hold every cycle.
